// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: field widths, opcode enums and channel structs.
package tlul_pkg;

  localparam int TL_AW    = 32;
  localparam int TL_DW    = 32;
  localparam int TL_MW    = TL_DW / 8;
  localparam int TL_SZW   = 3;
  localparam int TL_SRCW  = 2;
  localparam int TL_SINKW = 1;
  localparam int TL_OPW   = 3;
  localparam int TL_PW    = 3;

  typedef enum logic [TL_OPW-1:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [TL_OPW-1:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    logic [TL_OPW-1:0]  opcode;
    logic [TL_PW-1:0]   param;
    logic [TL_SZW-1:0]  size;
    logic [TL_SRCW-1:0] source;
    logic [TL_AW-1:0]   address;
    logic [TL_MW-1:0]   mask;
    logic [TL_DW-1:0]   data;
  } tl_a_t;

  typedef struct packed {
    logic [TL_OPW-1:0]   opcode;
    logic [TL_PW-1:0]    param;
    logic [TL_SZW-1:0]   size;
    logic [TL_SRCW-1:0]  source;
    logic [TL_SINKW-1:0] sink;
    logic [TL_DW-1:0]    data;
    logic                error;
  } tl_d_t;

endpackage

// File: rtl/tlul_sync_2ff.sv
// Two-flop synchronizer bringing asynchronous pin inputs into the clock domain.
module tlul_sync_2ff #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= {WIDTH{1'b0}};
      r_sync <= {WIDTH{1'b0}};
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tlul_gpio_slave.sv
// TL-UL device-side responder for a 32-pin GPIO block with edge interrupts.
// One outstanding transaction; responses are fully registered.
module tlul_gpio_slave
  import tlul_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    SRC_WIDTH    = 2,
  parameter int                    SINK_WIDTH   = 1,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_a_valid,
  output logic                    o_a_ready,
  input  logic [OPCODE_WIDTH-1:0] i_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  i_a_param,
  input  logic [SIZE_WIDTH-1:0]   i_a_size,
  input  logic [SRC_WIDTH-1:0]    i_a_source,
  input  logic [ADDR_WIDTH-1:0]   i_a_address,
  input  logic [MASK_WIDTH-1:0]   i_a_mask,
  input  logic [DATA_WIDTH-1:0]   i_a_data,
  output logic                    o_d_valid,
  input  logic                    i_d_ready,
  output logic [OPCODE_WIDTH-1:0] o_d_opcode,
  output logic [PARAM_WIDTH-1:0]  o_d_param,
  output logic [SIZE_WIDTH-1:0]   o_d_size,
  output logic [SRC_WIDTH-1:0]    o_d_source,
  output logic [SINK_WIDTH-1:0]   o_d_sink,
  output logic [DATA_WIDTH-1:0]   o_d_data,
  output logic                    o_d_error,
  input  logic [DATA_WIDTH-1:0]   i_gpio_in,
  output logic [DATA_WIDTH-1:0]   o_gpio_out,
  output logic [DATA_WIDTH-1:0]   o_gpio_oe,
  output logic                    o_intr
);

  localparam logic [2:0] OFF_OUT         = 3'd0;
  localparam logic [2:0] OFF_OE          = 3'd1;
  localparam logic [2:0] OFF_IN          = 3'd2;
  localparam logic [2:0] OFF_INTR_STATE  = 3'd3;
  localparam logic [2:0] OFF_INTR_ENABLE = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Expands the byte mask into a per-bit write mask.
  function automatic logic [DATA_WIDTH-1:0] mask_to_bits(input logic [MASK_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] b;
    b = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < MASK_WIDTH; i++) begin
      b[8*i +: 8] = {8{m[i]}};
    end
    return b;
  endfunction

  state_e                  r_state;
  state_e                  w_state_next;
  logic [DATA_WIDTH-1:0]   w_gpio_sync;
  logic [DATA_WIDTH-1:0]   r_sync_prev;
  logic [DATA_WIDTH-1:0]   r_out;
  logic [DATA_WIDTH-1:0]   r_oe;
  logic [DATA_WIDTH-1:0]   r_intr_state;
  logic [DATA_WIDTH-1:0]   r_intr_en;
  logic [OPCODE_WIDTH-1:0] r_d_opcode;
  logic [SIZE_WIDTH-1:0]   r_d_size;
  logic [SRC_WIDTH-1:0]    r_d_source;
  logic [DATA_WIDTH-1:0]   r_d_data;
  logic                    r_d_error;

  logic                    w_accept;
  logic                    w_is_get;
  logic                    w_is_put;
  logic                    w_error;
  logic                    w_wr_en;
  logic [2:0]              w_offset;
  logic [DATA_WIDTH-1:0]   w_bits;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic [DATA_WIDTH-1:0]   w_rise;
  logic [DATA_WIDTH-1:0]   w_clr;
  logic                    w_unused_param;

  assign w_unused_param = ^i_a_param;

  tlul_sync_2ff #(.WIDTH(DATA_WIDTH)) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_gpio_in),
    .o_q       (w_gpio_sync)
  );

  // Request decode, error classification and read-data selection.
  always_comb begin
    w_offset = i_a_address[4:2];
    w_accept = (r_state == ST_IDLE) && i_a_valid;
    w_is_get = (i_a_opcode == GET);
    w_is_put = (i_a_opcode == PUT_FULL_DATA) || (i_a_opcode == PUT_PARTIAL_DATA);
    w_error  = (i_a_address[ADDR_WIDTH-1:5] != BASE_ADDR[ADDR_WIDTH-1:5])
            || (w_offset > OFF_INTR_ENABLE)
            || !(w_is_get || w_is_put)
            || (i_a_size > SIZE_WIDTH'(2))
            || (i_a_address[1:0] != 2'b00)
            || ((i_a_opcode == PUT_FULL_DATA) && (!(&i_a_mask) || (i_a_size != SIZE_WIDTH'(2))))
            || (w_is_put && (w_offset == OFF_IN));
    w_wr_en  = w_accept && w_is_put && !w_error;
    w_bits   = mask_to_bits(i_a_mask);
    w_rise   = w_gpio_sync & ~r_sync_prev;
    if (w_wr_en && (w_offset == OFF_INTR_STATE)) begin
      w_clr = i_a_data & w_bits;
    end else begin
      w_clr = {DATA_WIDTH{1'b0}};
    end
    case (w_offset)
      OFF_OUT:         w_rdata = r_out;
      OFF_OE:          w_rdata = r_oe;
      OFF_IN:          w_rdata = w_gpio_sync;
      OFF_INTR_STATE:  w_rdata = r_intr_state;
      OFF_INTR_ENABLE: w_rdata = r_intr_en;
      default:         w_rdata = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Next-state logic: accept in IDLE, hold the response until D handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_a_valid) begin
          w_state_next = ST_RESP;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (i_d_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RESP;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // GPIO registers, edge-detect flop and interrupt status (set beats clear).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_out        <= {DATA_WIDTH{1'b0}};
      r_oe         <= {DATA_WIDTH{1'b0}};
      r_intr_en    <= {DATA_WIDTH{1'b0}};
      r_intr_state <= {DATA_WIDTH{1'b0}};
      r_sync_prev  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_sync_prev  <= w_gpio_sync;
      r_intr_state <= (r_intr_state & ~w_clr) | w_rise;
      if (w_wr_en && (w_offset == OFF_OUT)) begin
        r_out <= (r_out & ~w_bits) | (i_a_data & w_bits);
      end
      if (w_wr_en && (w_offset == OFF_OE)) begin
        r_oe <= (r_oe & ~w_bits) | (i_a_data & w_bits);
      end
      if (w_wr_en && (w_offset == OFF_INTR_ENABLE)) begin
        r_intr_en <= (r_intr_en & ~w_bits) | (i_a_data & w_bits);
      end
    end
  end

  // Response fields captured at acceptance and held until the next one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_d_opcode <= {OPCODE_WIDTH{1'b0}};
      r_d_size   <= {SIZE_WIDTH{1'b0}};
      r_d_source <= {SRC_WIDTH{1'b0}};
      r_d_data   <= {DATA_WIDTH{1'b0}};
      r_d_error  <= 1'b0;
    end else if (w_accept) begin
      r_d_opcode <= w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      r_d_size   <= i_a_size;
      r_d_source <= i_a_source;
      r_d_data   <= (w_is_get && !w_error) ? w_rdata : {DATA_WIDTH{1'b0}};
      r_d_error  <= w_error;
    end
  end

  assign o_a_ready  = (r_state == ST_IDLE);
  assign o_d_valid  = (r_state == ST_RESP);
  assign o_d_opcode = r_d_opcode;
  assign o_d_param  = {PARAM_WIDTH{1'b0}};
  assign o_d_size   = r_d_size;
  assign o_d_source = r_d_source;
  assign o_d_sink   = {SINK_WIDTH{1'b0}};
  assign o_d_data   = r_d_data;
  assign o_d_error  = r_d_error;
  assign o_gpio_out = r_out;
  assign o_gpio_oe  = r_oe;
  assign o_intr     = |(r_intr_state & r_intr_en);

endmodule
